cmpt_seq_ctrl: RTL and testbench
================================

Name: cmpt_seq_ctrl

Overview:
- Sequencer/controller for the team's 8-bit up-counter datapath.
- Adds start/pause/clear control, a programmable prescaler, a programmable terminal count (top), one-shot or periodic mode, a done pulse, and a level interrupt with acknowledge handshake.
- Sits between host/config logic and the counter; drives the count value seen on the output pins.

Parameters:
- CW, 8, counter width (cmpt, top).
- PW, 4, prescaler width (presc).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse: start from IDLE/DONE, or resume from PAUSE.
- stop  in  1  pulse: pause while RUN.
- clr  in  1  pulse: abort to IDLE, clear count, clear ovf.
- mode  in  1  0 = one-shot, 1 = periodic; sampled at start from IDLE/DONE.
- top  in  CW  terminal count; sampled at start from IDLE/DONE.
- presc  in  PW  tick divider (tick every presc+1 clocks); sampled with top.
- irq_ack  in  1  clears irq.
- cmpt  out  CW  current count.
- busy  out  1  1 in RUN or PAUSE.
- done  out  1  one-cycle pulse per terminal event.
- irq  out  1  sticky event flag.
- ovf  out  1  sticky: terminal event occurred while irq already set.

Behaviour:
- Reset (rst_n=0, async): state IDLE, cmpt=0, prescaler pc=0, busy=0, done=0, irq=0, ovf=0, shadow regs top_s=0, presc_s=0, mode_s=0.
- All outputs registered. Internal tick = RUN && pc==presc_s. On tick pc←0, otherwise in RUN pc←pc+1.
- States IDLE, RUN, PAUSE, DONE:
  - IDLE: cmpt=0. start → latch top/presc/mode into shadows, pc←0, cmpt←0, go RUN next edge.
  - RUN, tick with cmpt!=top_s: cmpt←cmpt+1.
  - RUN, tick with cmpt==top_s (terminal event): done←1 for one cycle, irq←1.
    - periodic: cmpt←0, stay RUN.
    - one-shot: cmpt holds top_s, go DONE.
  - RUN, stop → PAUSE. cmpt and pc frozen; no tick in the stop cycle.
  - PAUSE: start → RUN, resume with the same cmpt/pc; shadows are not reloaded.
  - DONE: cmpt holds top_s, busy=0. start → reload shadows, cmpt←0, RUN.
- Priority in the same cycle: clr > stop > start > tick.
  - clr from any state → IDLE, cmpt=0, pc=0, done=0, ovf=0. irq is unaffected except by irq_ack.
  - stop and start together in RUN → PAUSE.
- Period: (top_s+1)*(presc_s+1) clocks per terminal event. First increment occurs presc_s+1 clocks after entering RUN.
- top=0: every tick is a terminal event and cmpt stays 0. presc=0: tick every RUN cycle. top=255: full wrap 255→0, no width overflow.
- irq handshake:
  - Set on terminal event; cleared by irq_ack.
  - Set and ack in the same cycle → irq stays 1.
  - Event while irq==1 → ovf←1.
- top/presc/mode changes during RUN/PAUSE have no effect until the next start from IDLE/DONE.
- Reset asserted mid-operation: immediate return to reset values regardless of clk.

Decomposition:
- Shared package cmpt_pkg holds:
  - state enum: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, DONE=2'b11;
  - CW/PW default constants.
- One sub-module cmpt_core: CW-bit counter with async active-low reset, inputs en, clr, and output q. The controller drives en=tick&&!terminal and clr=(start-reload or periodic wrap or clr).
- FSM, prescaler, shadows and irq/ovf logic live in cmpt_seq_ctrl.

Test Plan:
- Reset: hold rst_n=0 mid-RUN with top=5 → all outputs 0 and state IDLE immediately, without waiting for a clock edge.
- Periodic: mode=1, top=3, presc=0, start at cycle 0.
  - Expect cmpt 0,1,2,3,0,1… from cycle 1.
  - done pulses on the 3→0 edge every 4 clocks; irq=1 after the first wrap.
  - Second wrap without ack → ovf=1.
- One-shot with prescaler: mode=0, top=2, presc=2.
  - Expect cmpt to increment every 3 clocks.
  - cmpt reaches 2, holds; done pulses once; state DONE with busy=0, 9 clocks after entering RUN.
  - start again → cmpt back to 0, busy=1.
- Pause/resume: periodic top=10, presc=0; stop when cmpt=4.
  - cmpt holds 4 for 5 cycles.
  - start resumes 5,6…; changing top to 2 during PAUSE has no effect (wrap still at 10).
- Priority: assert stop and start together in RUN → PAUSE. Assert clr and start together → IDLE, cmpt=0, ovf cleared.
- Boundaries:
  - top=0, presc=0, periodic → done every cycle, cmpt constant 0.
  - top=255 → wrap 255→0 after 256 ticks.
  - irq_ack in the same cycle as an event → irq remains 1.

Source files
------------

// File: rtl/cmpt_pkg.sv
// Shared types and default widths for the counter sequencer.
package cmpt_pkg;
   localparam int CW_DEF = 8;
   localparam int PW_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_e;
endpackage

// File: rtl/cmpt_seq_ctrl_if.sv
// Host-side control/status bundle of the counter sequencer.
interface cmpt_seq_ctrl_if #(
   parameter int CW = 8,
   parameter int PW = 4
);
   logic          start;
   logic          stop;
   logic          clr;
   logic          mode;
   logic [CW-1:0] top;
   logic [PW-1:0] presc;
   logic          irq_ack;
   logic [CW-1:0] cmpt;
   logic          busy;
   logic          done;
   logic          irq;
   logic          ovf;

   modport master (
      output start, stop, clr, mode, top, presc, irq_ack,
      input  cmpt, busy, done, irq, ovf
   );

   modport slave (
      input  start, stop, clr, mode, top, presc, irq_ack,
      output cmpt, busy, done, irq, ovf
   );
endinterface

// File: rtl/cmpt_core.sv
// Plain up-counter datapath; clear wins over enable.
module cmpt_core import cmpt_pkg::*; #(
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          clr,
   output logic [CW-1:0] q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   q <= '0;
      else if (clr) q <= '0;
      else if (en)  q <= q + CW'(1);
   end
endmodule

// File: rtl/cmpt_seq_ctrl.sv
// Start/pause/clear sequencer with prescaler, terminal count, done pulse and irq/ovf flags.
module cmpt_seq_ctrl import cmpt_pkg::*; #(
   parameter int CW = CW_DEF,
   parameter int PW = PW_DEF
) (
   input logic             clk,
   input logic             rst_n,
   cmpt_seq_ctrl_if.slave  bus
);
   localparam logic [1:0] S_IDLE  = 2'(IDLE);
   localparam logic [1:0] S_RUN   = 2'(RUN);
   localparam logic [1:0] S_PAUSE = 2'(PAUSE);
   localparam logic [1:0] S_DONE  = 2'(DONE);

   logic [1:0]    state, state_nxt;
   logic [PW-1:0] pc, presc_s;
   logic [CW-1:0] top_s, cnt;
   logic          mode_s;
   logic          busy_q, done_q, irq_q, ovf_q;
   logic          run, go, reload, tick, term, core_en, core_clr;

   // Priority clr > stop > start > tick is folded into go and tick.
   assign run      = (state == S_RUN);
   assign go       = bus.start && !bus.stop && !bus.clr;
   assign reload   = go && (state == S_IDLE || state == S_DONE);
   assign tick     = run && !bus.stop && !bus.clr && (pc == presc_s);
   assign term     = tick && (cnt == top_s);
   assign core_en  = tick && !term;
   assign core_clr = bus.clr || reload || (term && mode_s);

   cmpt_core #(.CW(CW)) u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (core_en),
      .clr   (core_clr),
      .q     (cnt)
   );

   always_comb begin
      state_nxt = state;
      if (bus.clr) state_nxt = S_IDLE;
      else begin
         case (state)
            S_IDLE, S_DONE: if (go) state_nxt = S_RUN;
            S_RUN: begin
               if (bus.stop)             state_nxt = S_PAUSE;
               else if (term && !mode_s) state_nxt = S_DONE;
            end
            S_PAUSE: if (go) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         pc      <= '0;
         top_s   <= '0;
         presc_s <= '0;
         mode_s  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         irq_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state  <= state_nxt;
         busy_q <= (state_nxt == S_RUN) || (state_nxt == S_PAUSE);
         done_q <= term;

         if (bus.clr || reload)      pc <= '0;
         else if (run && !bus.stop)  pc <= tick ? '0 : pc + PW'(1);

         if (reload) begin
            top_s   <= bus.top;
            presc_s <= bus.presc;
            mode_s  <= bus.mode;
         end

         // A new event beats a same-cycle acknowledge.
         if (term)             irq_q <= 1'b1;
         else if (bus.irq_ack) irq_q <= 1'b0;

         if (bus.clr)            ovf_q <= 1'b0;
         else if (term && irq_q) ovf_q <= 1'b1;
      end
   end

   assign bus.cmpt = cnt;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.irq  = irq_q;
   assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_cmpt_seq_ctrl.sv
// Scenario bench for cmpt_seq_ctrl: expected outputs queued per cycle, compared at the falling edge.
module tb_cmpt_seq_ctrl;
   import cmpt_pkg::*;

   typedef struct packed {
      logic [7:0] cmpt;
      logic       busy;
      logic       done;
      logic       irq;
      logic       ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   cmpt_seq_ctrl_if #(.CW(8), .PW(4)) bus ();

   cmpt_seq_ctrl #(.CW(8), .PW(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Inputs change at a falling edge; outputs are read at the next falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_all();
      bus.clr = 1'b1; bus.irq_ack = 1'b1;
      cyc();
      bus.clr = 1'b0; bus.irq_ack = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e, got;
      bus.start = 0; bus.stop = 0; bus.clr = 0; bus.mode = 0;
      bus.top = 8'd5; bus.presc = 4'd0; bus.irq_ack = 0;
      rst_n = 1'b0;
      cyc(); cyc();
      got = {bus.cmpt, bus.busy, bus.done, bus.irq, bus.ovf};
      checks++;
      if (got !== '0) begin errors++; $display("FAIL reset_init got=%b exp=0", got); end
      rst_n = 1'b1;
      cyc();
      for (int k = 0; k <= 2; k++) begin
         bus.start = (k == 0);
         sb.push_back('{cmpt:8'(k), busy:1'b1, done:1'b0, irq:1'b0, ovf:1'b0});
         cyc();
         got = {bus.cmpt, bus.busy, bus.done, bus.irq, bus.ovf};
         e = sb.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL reset_prerun k=%0d got=%b exp=%b", k, got, e); end
      end
      bus.start = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      got = {bus.cmpt, bus.busy, bus.done, bus.irq, bus.ovf};
      checks++;
      if (got !== '0) begin errors++; $display("FAIL reset_async got=%b exp=0", got); end
      checks++;
      if (dut.state !== 2'(IDLE)) begin errors++; $display("FAIL reset_state got=%b exp=%b", dut.state, 2'(IDLE)); end
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_periodic();
      exp_t e, got;
      clear_all();
      bus.mode = 1'b1; bus.top = 8'd3; bus.presc = 4'd0;
      for (int k = 0; k <= 10; k++) begin
         bus.start = (k == 0);
         sb.push_back('{cmpt:8'(k % 4), busy:1'b1, done:(k > 0 && k % 4 == 0), irq:(k >= 4), ovf:(k >= 8)});
         cyc();
         got = {bus.cmpt, bus.busy, bus.done, bus.irq, bus.ovf};
         e = sb.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL periodic k=%0d got=%b exp=%b", k, got, e); end
      end
      bus.start = 1'b0;
   endtask

   task automatic test_oneshot();
      exp_t e, got;
      clear_all();
      bus.mode = 1'b0; bus.top = 8'd2; bus.presc = 4'd2;
      for (int k = 0; k <= 13; k++) begin
         bus.start = (k == 0 || k == 12);
         if (k < 12)
            sb.push_back('{cmpt:8'((k / 3 > 2) ? 2 : k / 3), busy:(k < 9), done:(k == 9), irq:(k >= 9), ovf:1'b0});
         else
            sb.push_back('{cmpt:8'd0, busy:1'b1, done:1'b0, irq:1'b1, ovf:1'b0});
         cyc();
         got = {bus.cmpt, bus.busy, bus.done, bus.irq, bus.ovf};
         e = sb.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL oneshot k=%0d got=%b exp=%b", k, got, e); end
      end
      bus.start = 1'b0;
   endtask

   task automatic test_pause();
      exp_t e, got;
      int c;
      clear_all();
      bus.mode = 1'b1; bus.top = 8'd10; bus.presc = 4'd0;
      for (int k = 0; k <= 18; k++) begin
         bus.start = (k == 0 || k == 10);
         bus.stop  = (k == 5);
         if (k == 6) bus.top = 8'd2;
         c = (k <= 4) ? k : (k <= 10) ? 4 : (k <= 16) ? k - 6 : k - 17;
         sb.push_back('{cmpt:8'(c), busy:1'b1, done:(k == 17), irq:(k >= 17), ovf:1'b0});
         cyc();
         got = {bus.cmpt, bus.busy, bus.done, bus.irq, bus.ovf};
         e = sb.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL pause k=%0d got=%b exp=%b", k, got, e); end
      end
      bus.start = 1'b0; bus.stop = 1'b0;
   endtask

   task automatic test_priority();
      exp_t e, got;
      clear_all();
      bus.mode = 1'b1; bus.top = 8'd10; bus.presc = 4'd0;
      for (int k = 0; k <= 5; k++) begin
         bus.start = (k == 0 || k == 3);
         bus.stop  = (k == 3);
         sb.push_back('{cmpt:8'((k < 2) ? k : 2), busy:1'b1, done:1'b0, irq:1'b0, ovf:1'b0});
         cyc();
         got = {bus.cmpt, bus.busy, bus.done, bus.irq, bus.ovf};
         e = sb.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL prio_stop_start k=%0d got=%b exp=%b", k, got, e); end
      end
      bus.start = 1'b0; bus.stop = 1'b0;
      clear_all();
      bus.top = 8'd0;
      for (int k = 0; k <= 5; k++) begin
         bus.start = (k == 0 || k == 4);
         bus.clr   = (k == 4);
         sb.push_back('{cmpt:8'd0, busy:(k < 4), done:(k >= 1 && k < 4), irq:(k >= 1), ovf:(k >= 2 && k < 4)});
         cyc();
         got = {bus.cmpt, bus.busy, bus.done, bus.irq, bus.ovf};
         e = sb.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL prio_clr_start k=%0d got=%b exp=%b", k, got, e); end
      end
      bus.start = 1'b0; bus.clr = 1'b0;
   endtask

   task automatic test_top0();
      exp_t e, got;
      clear_all();
      bus.mode = 1'b1; bus.top = 8'd0; bus.presc = 4'd0;
      for (int k = 0; k <= 6; k++) begin
         bus.start = (k == 0);
         sb.push_back('{cmpt:8'd0, busy:1'b1, done:(k >= 1), irq:(k >= 1), ovf:(k >= 2)});
         cyc();
         got = {bus.cmpt, bus.busy, bus.done, bus.irq, bus.ovf};
         e = sb.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL top0 k=%0d got=%b exp=%b", k, got, e); end
      end
      bus.start = 1'b0;
   endtask

   task automatic test_top255();
      exp_t e, got;
      clear_all();
      bus.mode = 1'b1; bus.top = 8'd255; bus.presc = 4'd0;
      for (int k = 0; k <= 258; k++) begin
         bus.start = (k == 0);
         sb.push_back('{cmpt:8'(k % 256), busy:1'b1, done:(k == 256), irq:(k >= 256), ovf:1'b0});
         cyc();
         got = {bus.cmpt, bus.busy, bus.done, bus.irq, bus.ovf};
         e = sb.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL top255 k=%0d got=%b exp=%b", k, got, e); end
      end
      bus.start = 1'b0;
   endtask

   task automatic test_irq_ack();
      exp_t e, got;
      clear_all();
      bus.mode = 1'b1; bus.top = 8'd1; bus.presc = 4'd0;
      for (int k = 0; k <= 7; k++) begin
         bus.start   = (k == 0);
         bus.irq_ack = (k == 3 || k == 4 || k == 6);
         sb.push_back('{cmpt:8'(k % 2), busy:1'b1, done:(k >= 2 && k % 2 == 0),
                        irq:(k >= 2 && k != 3), ovf:(k >= 6)});
         cyc();
         got = {bus.cmpt, bus.busy, bus.done, bus.irq, bus.ovf};
         e = sb.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL irq_ack k=%0d got=%b exp=%b", k, got, e); end
      end
      bus.start = 1'b0; bus.irq_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_oneshot();
      test_pause();
      test_priority();
      test_top0();
      test_top255();
      test_irq_ack();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
